// File: rtl/uk101_kbd_pkg.sv
// uk101_kbd_pkg
// Shared definitions for the UK101 PS/2 keyboard matrix block:
//   - PS/2 set-2 prefix byte constants
//   - receiver FSM state encoding
//   - key_pos_t, a matrix position with a valid flag
//   - map_scancode(), the UK101 keyboard layout table
//   - the fixed position of the latching SHIFT LOCK key
package uk101_kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  localparam logic [2:0] SHIFT_LOCK_ROW = 3'd0;
  localparam logic [2:0] SHIFT_LOCK_COL = 3'd0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t kp(input logic [2:0] r, input logic [2:0] c);
    key_pos_t p;
    p.valid = 1'b1;
    p.row   = r;
    p.col   = c;
    return p;
  endfunction

  // Lookup key is {ext, code}; bit 8 set means the byte followed an E0 prefix.
  // Tab stands in for REPEAT and backslash for LINE FEED, which have no
  // direct PC equivalents.
  function automatic key_pos_t map_scancode(input logic ext, input logic [7:0] code);
    key_pos_t p;
    p = '0;
    case ({ext, code})
      // row 0: SHIFT LOCK, shifts, ESC, CTRL, REPEAT
      9'h058: p = kp(3'd0, 3'd0);  9'h059: p = kp(3'd0, 3'd1);  9'h012: p = kp(3'd0, 3'd2);
      9'h076: p = kp(3'd0, 3'd5);  9'h014: p = kp(3'd0, 3'd6);  9'h114: p = kp(3'd0, 3'd6);
      9'h00D: p = kp(3'd0, 3'd7);
      // row 1: P ; / SPACE Z A Q
      9'h04D: p = kp(3'd1, 3'd1);  9'h04C: p = kp(3'd1, 3'd2);  9'h04A: p = kp(3'd1, 3'd3);
      9'h14A: p = kp(3'd1, 3'd3);  9'h029: p = kp(3'd1, 3'd4);  9'h01A: p = kp(3'd1, 3'd5);
      9'h01C: p = kp(3'd1, 3'd6);  9'h015: p = kp(3'd1, 3'd7);
      // row 2: , M N B V C X
      9'h041: p = kp(3'd2, 3'd1);  9'h03A: p = kp(3'd2, 3'd2);  9'h031: p = kp(3'd2, 3'd3);
      9'h032: p = kp(3'd2, 3'd4);  9'h02A: p = kp(3'd2, 3'd5);  9'h021: p = kp(3'd2, 3'd6);
      9'h022: p = kp(3'd2, 3'd7);
      // row 3: K J H G F D S
      9'h042: p = kp(3'd3, 3'd1);  9'h03B: p = kp(3'd3, 3'd2);  9'h033: p = kp(3'd3, 3'd3);
      9'h034: p = kp(3'd3, 3'd4);  9'h02B: p = kp(3'd3, 3'd5);  9'h023: p = kp(3'd3, 3'd6);
      9'h01B: p = kp(3'd3, 3'd7);
      // row 4: I U Y T R E W
      9'h043: p = kp(3'd4, 3'd1);  9'h03C: p = kp(3'd4, 3'd2);  9'h035: p = kp(3'd4, 3'd3);
      9'h02C: p = kp(3'd4, 3'd4);  9'h02D: p = kp(3'd4, 3'd5);  9'h024: p = kp(3'd4, 3'd6);
      9'h01D: p = kp(3'd4, 3'd7);
      // row 5: RETURN LF O L .
      9'h05A: p = kp(3'd5, 3'd3);  9'h15A: p = kp(3'd5, 3'd3);  9'h05D: p = kp(3'd5, 3'd4);
      9'h044: p = kp(3'd5, 3'd5);  9'h04B: p = kp(3'd5, 3'd6);  9'h049: p = kp(3'd5, 3'd7);
      // row 6: RUBOUT - : 0 9 8
      9'h066: p = kp(3'd6, 3'd1);  9'h04E: p = kp(3'd6, 3'd2);  9'h052: p = kp(3'd6, 3'd3);
      9'h045: p = kp(3'd6, 3'd4);  9'h046: p = kp(3'd6, 3'd5);  9'h03E: p = kp(3'd6, 3'd6);
      // row 7: 7 6 5 4 3 2 1
      9'h03D: p = kp(3'd7, 3'd1);  9'h036: p = kp(3'd7, 3'd2);  9'h02E: p = kp(3'd7, 3'd3);
      9'h025: p = kp(3'd7, 3'd4);  9'h026: p = kp(3'd7, 3'd5);  9'h01E: p = kp(3'd7, 3'd6);
      9'h016: p = kp(3'd7, 3'd7);
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uk101_ps2_keymatrix_if.sv
// uk101_ps2_keymatrix_if
// Groups the PS/2 lines, the CPU keyboard port and the status pulses of
// uk101_ps2_keymatrix.
//   ps2Clk, ps2Data : PS/2 lines from hps_io (asynchronous)
//   row_sel         : row-select byte written by the CPU, bit i = 0 selects row i
//   col_out         : column byte read by the CPU, bit j = 0 when key j pressed
//   byte_strobe     : one-cycle pulse per valid received byte
//   frame_err       : one-cycle pulse per rejected or abandoned frame
// slave is the keyboard block's view, master the surrounding system's view.
interface uk101_ps2_keymatrix_if;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] row_sel;
  logic [7:0] col_out;
  logic       byte_strobe;
  logic       frame_err;

  modport slave  (input ps2Clk, ps2Data, row_sel, output col_out, byte_strobe, frame_err);
  modport master (output ps2Clk, ps2Data, row_sel, input col_out, byte_strobe, frame_err);
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx
// PS/2 byte receiver: 2-FF synchronisers and 4-sample glitch filters on both
// lines, an 11-bit frame FSM (start, 8 data LSB first, odd parity, stop) and
// an inter-edge timeout that abandons stalled frames.
//   clk, n_reset : system clock, asynchronous active-low reset
//   ps2_clk/data : raw PS/2 lines
//   byte_strobe  : one-cycle pulse, data holds the received byte
//   data         : last received byte
//   frame_err    : one-cycle pulse on start, parity, stop or timeout error
module ps2_rx
  import uk101_kbd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 200
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_strobe,
  output logic [7:0] data,
  output logic       frame_err
);

  // Divided in two steps so the product stays inside 32 bits.
  localparam int TO_RELOAD = (TIMEOUT_US * (CLK_HZ / 1000)) / 1000 - 1;
  localparam int TO_W      = $clog2(TO_RELOAD + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_RELOAD);

  logic [1:0]      clk_sync_q, dat_sync_q;
  logic [2:0]      clk_hist_q, dat_hist_q;
  logic            clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic            fall;
  rx_state_t       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            strobe_q, strobe_d, err_q, err_d;

  // The synchronised sample plus the three before it must all agree before
  // the filtered level moves; anything shorter is treated as a glitch.
  always_comb begin
    clk_filt_d = clk_filt_q;
    dat_filt_d = dat_filt_q;
    if (&{clk_hist_q, clk_sync_q[1]})       clk_filt_d = 1'b1;
    else if (~|{clk_hist_q, clk_sync_q[1]}) clk_filt_d = 1'b0;
    if (&{dat_hist_q, dat_sync_q[1]})       dat_filt_d = 1'b1;
    else if (~|{dat_hist_q, dat_sync_q[1]}) dat_filt_d = 1'b0;
  end

  assign fall = clk_filt_q & ~clk_filt_d;

  // Frame FSM and timeout. Every PS/2 clock fall reloads the timeout; if it
  // runs out mid-frame the partial frame is dropped.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    to_cnt_d  = (to_cnt_q != '0) ? to_cnt_q - TO_W'(1) : to_cnt_q;
    if (fall) begin
      to_cnt_d = TO_LOAD;
      case (state_q)
        RX_IDLE: begin
          if (!dat_filt_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_filt_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          parity_d = dat_filt_q;
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (dat_filt_q && (^{shift_q, parity_q})) strobe_d = 1'b1;
          else                                      err_d    = 1'b1;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && to_cnt_q == '0) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end
  end

  // Idle PS/2 lines are high, so the conditioning chain resets high to avoid
  // a false fall coming out of reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_hist_q <= '1;
      dat_hist_q <= '1;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      to_cnt_q   <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_hist_q <= {clk_hist_q[1:0], clk_sync_q[1]};
      dat_hist_q <= {dat_hist_q[1:0], dat_sync_q[1]};
      clk_filt_q <= clk_filt_d;
      dat_filt_q <= dat_filt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      to_cnt_q   <= to_cnt_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  assign byte_strobe = strobe_q;
  assign data        = shift_q;
  assign frame_err   = err_q;

endmodule

// File: rtl/uk101_ps2_keymatrix.sv
// uk101_ps2_keymatrix
// Turns the PS/2 byte stream into the UK101 8x8 keyboard matrix and drives
// the active-low column byte for the row(s) the CPU selects.
//   clk, n_reset : system clock, asynchronous active-low reset
//   kbd          : PS/2 lines, row_sel in, col_out/byte_strobe/frame_err out
module uk101_ps2_keymatrix
  import uk101_kbd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 200
) (
  input logic                   clk,
  input logic                   n_reset,
  uk101_ps2_keymatrix_if.slave  kbd
);

  logic             rx_strobe, rx_err;
  logic [7:0]       rx_data;
  logic [7:0][7:0]  matrix_q, matrix_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic [2:0]       skip_q, skip_d;
  logic [7:0]       col_q, col_d;
  key_pos_t         pos;

  ps2_rx #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US)) u_rx (
    .clk         (clk),
    .n_reset     (n_reset),
    .ps2_clk     (kbd.ps2Clk),
    .ps2_data    (kbd.ps2Data),
    .byte_strobe (rx_strobe),
    .data        (rx_data),
    .frame_err   (rx_err)
  );

  assign pos = map_scancode(ext_q, rx_data);

  // Byte decoder. Prefixes only set flags; the skip counter swallows the
  // Pause sequence; reset/BAT bytes release everything except SHIFT LOCK,
  // which latches and only toggles on make.
  always_comb begin
    matrix_d = matrix_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    if (rx_strobe) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (rx_data == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_data == SC_BRK) begin
        brk_d = 1'b1;
      end else if (rx_data == SC_PAUSE) begin
        skip_d = 3'd7;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (rx_data == SC_BAT || rx_data == 8'h00 || rx_data == 8'hFF) begin
          matrix_d = '0;
          matrix_d[SHIFT_LOCK_ROW][SHIFT_LOCK_COL] = matrix_q[SHIFT_LOCK_ROW][SHIFT_LOCK_COL];
        end else if (pos.valid) begin
          if (pos.row == SHIFT_LOCK_ROW && pos.col == SHIFT_LOCK_COL) begin
            if (!brk_q)
              matrix_d[SHIFT_LOCK_ROW][SHIFT_LOCK_COL] = ~matrix_q[SHIFT_LOCK_ROW][SHIFT_LOCK_COL];
          end else begin
            matrix_d[pos.row][pos.col] = ~brk_q;
          end
        end
      end
    end
  end

  // Column reduction: each selected row pulls its pressed columns low.
  always_comb begin
    col_d = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (!kbd.row_sel[i]) col_d = col_d & ~matrix_q[i];
    end
  end

  // State registers; SHIFT LOCK comes out of reset engaged.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      matrix_q <= '0;
      matrix_q[SHIFT_LOCK_ROW][SHIFT_LOCK_COL] <= 1'b1;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_q   <= '0;
      col_q    <= 8'hFF;
    end else begin
      matrix_q <= matrix_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      skip_q   <= skip_d;
      col_q    <= col_d;
    end
  end

  assign kbd.col_out     = col_q;
  assign kbd.byte_strobe = rx_strobe;
  assign kbd.frame_err   = rx_err;

endmodule

// File: tb/tb_uk101_ps2_keymatrix.sv
// tb_uk101_ps2_keymatrix
// Directed bench for uk101_ps2_keymatrix: sends PS/2 frames bit by bit and
// checks the column byte and the strobe/error pulse counts against
// hand-computed values.
module tb_uk101_ps2_keymatrix;

  localparam int HALF = 20;

  logic clk;
  logic n_reset;
  int   n_cmp;
  int   n_fail;
  int   strobe_cnt;
  int   err_cnt;

  uk101_ps2_keymatrix_if kbd ();

  uk101_ps2_keymatrix dut (
    .clk     (clk),
    .n_reset (n_reset),
    .kbd     (kbd)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Count output pulses so tests can compare before/after deltas.
  always @(posedge clk) begin
    if (kbd.byte_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    if (kbd.frame_err === 1'b1)   err_cnt    <= err_cnt + 1;
  end

  // Drive bits 0..nbits-1 of an 11-bit frame (start, data LSB first, odd
  // parity optionally inverted, stop), one PS/2 clock pulse per bit.
  task automatic applyStimulus(input logic [7:0] code, input logic bad_parity, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, (~^code) ^ bad_parity, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kbd.ps2Data = frame[i];
      repeat (HALF) @(negedge clk);
      kbd.ps2Clk = 1'b0;
      repeat (HALF) @(negedge clk);
      kbd.ps2Clk = 1'b1;
    end
    kbd.ps2Data = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] code);
    applyStimulus(code, 1'b0, 11);
  endtask

  task automatic set_row(input logic [7:0] v);
    kbd.row_sel = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    n_reset = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (kbd.col_out !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_col: got %h expected ff", kbd.col_out); end
    n_cmp++; if (kbd.byte_strobe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobe: got %b expected 0", kbd.byte_strobe); end
    n_cmp++; if (kbd.frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", kbd.frame_err); end
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    set_row(8'hFE);
    n_cmp++; if (kbd.col_out !== 8'hFE) begin n_fail++; $display("[TB] FAIL reset_shiftlock: got %h expected fe", kbd.col_out); end
    set_row(8'hFD);
    n_cmp++; if (kbd.col_out !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_row1: got %h expected ff", kbd.col_out); end
  endtask

  task automatic test_make_break;
    int s0;
    s0 = strobe_cnt;
    send(8'h1C);
    set_row(8'hFD);
    n_cmp++; if (kbd.col_out !== 8'hBF) begin n_fail++; $display("[TB] FAIL make_a: got %h expected bf", kbd.col_out); end
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("[TB] FAIL strobe_count: got %0d expected 1", strobe_cnt - s0); end
    set_row(8'hFE);
    n_cmp++; if (kbd.col_out !== 8'hFE) begin n_fail++; $display("[TB] FAIL a_row0_clean: got %h expected fe", kbd.col_out); end
    set_row(8'hFD);
    send(8'hF0);
    send(8'h1C);
    n_cmp++; if (kbd.col_out !== 8'hFF) begin n_fail++; $display("[TB] FAIL break_a: got %h expected ff", kbd.col_out); end
  endtask

  task automatic test_parity_error;
    int s0, e0;
    s0 = strobe_cnt;
    e0 = err_cnt;
    applyStimulus(8'h1C, 1'b1, 11);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("[TB] FAIL parity_err_count: got %0d expected 1", err_cnt - e0); end
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("[TB] FAIL parity_no_strobe: got %0d expected 0", strobe_cnt - s0); end
    n_cmp++; if (kbd.col_out !== 8'hFF) begin n_fail++; $display("[TB] FAIL parity_matrix: got %h expected ff", kbd.col_out); end
  endtask

  task automatic test_timeout;
    int s0, e0;
    s0 = strobe_cnt;
    e0 = err_cnt;
    applyStimulus(8'h1C, 1'b0, 5);
    repeat (8950) @(negedge clk);
    n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("[TB] FAIL timeout_early: got %0d expected 0", err_cnt - e0); end
    repeat (1500) @(negedge clk);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("[TB] FAIL timeout_err: got %0d expected 1", err_cnt - e0); end
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("[TB] FAIL timeout_no_strobe: got %0d expected 0", strobe_cnt - s0); end
    send(8'h1C);
    n_cmp++; if (kbd.col_out !== 8'hBF) begin n_fail++; $display("[TB] FAIL after_timeout_a: got %h expected bf", kbd.col_out); end
  endtask

  task automatic test_shift_lock;
    set_row(8'hFE);
    send(8'h58);
    n_cmp++; if (kbd.col_out !== 8'hFF) begin n_fail++; $display("[TB] FAIL shiftlock_off: got %h expected ff", kbd.col_out); end
    send(8'hF0);
    send(8'h58);
    n_cmp++; if (kbd.col_out !== 8'hFF) begin n_fail++; $display("[TB] FAIL shiftlock_break: got %h expected ff", kbd.col_out); end
    send(8'h58);
    n_cmp++; if (kbd.col_out !== 8'hFE) begin n_fail++; $display("[TB] FAIL shiftlock_on: got %h expected fe", kbd.col_out); end
  endtask

  task automatic test_bat_and_pause;
    set_row(8'hFD);
    n_cmp++; if (kbd.col_out !== 8'hBF) begin n_fail++; $display("[TB] FAIL a_held: got %h expected bf", kbd.col_out); end
    send(8'hAA);
    n_cmp++; if (kbd.col_out !== 8'hFF) begin n_fail++; $display("[TB] FAIL bat_release: got %h expected ff", kbd.col_out); end
    set_row(8'hFE);
    n_cmp++; if (kbd.col_out !== 8'hFE) begin n_fail++; $display("[TB] FAIL bat_keeps_lock: got %h expected fe", kbd.col_out); end
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    n_cmp++; if (kbd.col_out !== 8'hFE) begin n_fail++; $display("[TB] FAIL pause_ignored: got %h expected fe", kbd.col_out); end
    send(8'h1C);
    set_row(8'h00);
    n_cmp++; if (kbd.col_out !== 8'hBE) begin n_fail++; $display("[TB] FAIL after_pause_all_rows: got %h expected be", kbd.col_out); end
  endtask

  task automatic test_reset_midframe;
    applyStimulus(8'h1C, 1'b0, 4);
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    set_row(8'h00);
    n_cmp++; if (kbd.col_out !== 8'hFE) begin n_fail++; $display("[TB] FAIL midreset_matrix: got %h expected fe", kbd.col_out); end
    send(8'h1C);
    set_row(8'hFD);
    n_cmp++; if (kbd.col_out !== 8'hBF) begin n_fail++; $display("[TB] FAIL midreset_next_frame: got %h expected bf", kbd.col_out); end
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    strobe_cnt  = 0;
    err_cnt     = 0;
    n_reset     = 1'b0;
    kbd.ps2Clk  = 1'b1;
    kbd.ps2Data = 1'b1;
    kbd.row_sel = 8'hFF;
    test_reset;
    test_make_break;
    test_parity_error;
    test_timeout;
    test_shift_lock;
    test_bat_and_pause;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uk101_ps2_keymatrix.md
# uk101_ps2_keymatrix

Converts the PS/2 keyboard stream from the HPS into the UK101's 8×8 active-low keyboard matrix. The CPU writes a row-select byte to the keyboard port and reads back the column byte. The block sits between the HPS PS/2 outputs (`ps2Clk`/`ps2Data`) and the keyboard port decode inside `uk101`. It holds key state for every mapped key, handles make/break/extended prefixes, and implements the latching SHIFT LOCK key.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000 — clk frequency in Hz; used to size the frame timeout.
- `TIMEOUT_US`, 200 — maximum gap between PS/2 clock falls inside a frame before the frame is abandoned.

Ports:
- `clk` in 1 — system clock (clk_sys, 50 MHz).
- `n_reset` in 1 — reset, asynchronous, active-low.
- `ps2Clk` in 1 — PS/2 clock from hps_io; treated as asynchronous.
- `ps2Data` in 1 — PS/2 data from hps_io; treated as asynchronous.
- `row_sel` in 8 — row-select byte last written by the CPU; bit i = 0 selects row i.
- `col_out` out 8 — column byte; bit j = 0 when any selected row has key j pressed.
- `byte_strobe` out 1 — one-cycle pulse for each valid received byte.
- `frame_err` out 1 — one-cycle pulse on parity, start, stop or timeout error.

## Operation
- **Input conditioning:** `ps2Clk` and `ps2Data` each pass through a 2-FF synchroniser, then a 4-sample glitch filter. The filtered clock output changes only after 4 equal consecutive samples. A falling edge of the filtered clock is `fall`.
- **Receiver FSM**, states IDLE → DATA → PARITY → STOP:
  - IDLE: on `fall` with data 0, go to DATA and set bit count to 0. On `fall` with data 1, stay in IDLE and pulse `frame_err`.
  - DATA: on each `fall`, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, check stop = 1 and odd parity over 9 bits. On pass, pulse `byte_strobe` with the byte. On fail, pulse `frame_err` and drop the byte. Both cases return to IDLE.
  - Timeout: a counter reloads to TIMEOUT_US·CLK_HZ/10⁶ − 1 on every `fall`. If it reaches 0 while not in IDLE, return to IDLE and pulse `frame_err`.
- **Decoder**, acting on each valid byte:
  - E0 sets `ext`.
  - F0 sets `brk`.
  - E1 sets a skip counter to 7; the next 7 bytes are ignored (Pause sequence).
  - AA, 00 and FF clear every matrix bit except [0][0] and clear `ext` and `brk`.
  - Any other byte is looked up by {ext, code}. A hit yields (row, col). A miss is discarded.
  - On a hit for any key except SHIFT LOCK: set matrix[row][col] = ~brk.
  - SHIFT LOCK (Caps Lock, 58): a make toggles matrix[0][0]; a break is ignored.
  - After any non-prefix byte, clear `ext` and `brk`.
- **Column output:** col_out[j] = ~OR over i of (~row_sel[i] & matrix[i][j]), registered.
- **Reset values:**
  - matrix all 0 except [0][0] = 1 (SHIFT LOCK engaged).
  - FSM in IDLE; `ext`, `brk` and skip counter all 0.
  - `col_out` = 8'hFF; `byte_strobe` = 0; `frame_err` = 0.
- **Reset mid-frame:** discard the partial frame. The next frame is received normally once its start bit arrives.

## Timing
- `fall` is detected 6 clk after the raw PS/2 clock edge: 2 cycles of synchroniser plus 4 cycles of filter.
- `byte_strobe` pulses 1 clk after the `fall` of the stop bit.
- The matrix updates 1 clk after `byte_strobe`.
- `col_out` reflects a matrix or `row_sel` change 1 clk later.
- Worst case from stop-bit edge to `col_out` is 9 clk.
- A `row_sel` change and a matrix update in the same cycle: `col_out` uses both new values on the next cycle.
- Timeout at defaults is 10 000 clk.

## Structure
- Package `uk101_kbd_pkg` holds:
  - prefix constants SC_EXT=E0, SC_BRK=F0, SC_PAUSE=E1, SC_BAT=AA;
  - the `key_pos_t` struct {valid, row[2:0], col[2:0]};
  - function `map_scancode(ext, code)` containing the full UK101 layout table;
  - SHIFT LOCK position constant [0][0].
- Sub-module `ps2_rx` contains the synchroniser, filter, receiver FSM and timeout. Its outputs are `byte_strobe`, `data[7:0]` and `frame_err`.
- The top level holds the decoder flags, the 64-bit matrix and the column reduction.

## Test plan
1. Reset, then `row_sel` = FE → `col_out` = FE (SHIFT LOCK). `row_sel` = FD → `col_out` = FF.
2. Send 1C (A, mapped to row 1 col 6), then `row_sel` = FD → `col_out` = BF. Send F0 1C → `col_out` = FF.
3. Send a frame with parity flipped → `frame_err` pulses once, no `byte_strobe`, matrix unchanged.
4. Stop the PS/2 clock after 4 data bits for more than 10 000 clk → `frame_err` pulses and FSM returns to IDLE. A following valid 1C frame sets A.
5. Send 58 → [0][0] clears (`col_out` = FF with `row_sel` = FE). Send F0 58 → unchanged. Send 58 → `col_out` = FE.
6. Hold A, then send AA → A released and SHIFT LOCK retained. Send E1 14 77 E1 F0 14 F0 77, then 1C → only A is set.
